el2_exu_custom_rdout: RTL

- Unload side of the custom finite-field multiply unit.
- Operands enter through the ffload* custom instructions. This block captures the multiplier's WIDTH-bit result when the multiplier signals completion.
- It returns the result to the pipeline in 32-bit words, one word per decoded ffread* custom instruction (start / increment / end).
- It sits in the EXU beside the operand-load control. Its word output feeds the custom-instruction writeback mux.

---
 rtl/el2_exu_custom_rdout_if.sv | 30 +++
 rtl/el2_exu_custom_rdout.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/el2_exu_custom_rdout_if.sv
// Unload-side handshake of the custom finite-field multiply unit.
// The master is the EXU decode/multiplier side and the slave is el2_exu_custom_rdout.
interface el2_exu_custom_rdout_if #(
   parameter int WIDTH  = 409,
   parameter int NWORDS = 13,
   parameter int IDXW   = $clog2(NWORDS)
);
   logic             finish_p_i;
   logic [WIDTH-1:0] result_i;
   logic             clear_i;
   logic             rd_start_i;
   logic             rd_inc_i;
   logic             rd_end_i;
   logic [31:0]      rd_data_o;
   logic             rd_valid_o;
   logic             busy_o;
   logic             res_vld_o;
   logic [IDXW-1:0]  idx_o;
   logic             err_o;

   modport master (
      output finish_p_i, result_i, clear_i, rd_start_i, rd_inc_i, rd_end_i,
      input  rd_data_o, rd_valid_o, busy_o, res_vld_o, idx_o, err_o
   );

   modport slave (
      input  finish_p_i, result_i, clear_i, rd_start_i, rd_inc_i, rd_end_i,
      output rd_data_o, rd_valid_o, busy_o, res_vld_o, idx_o, err_o
   );
endinterface

// File: rtl/el2_exu_custom_rdout.sv
// Holds the finite-field multiplier result and returns it as 32-bit words on ffread* decodes.
// Define EL2_FFRD_STALL_EN to stall (busy_o) a request that arrives before the result exists.
module el2_exu_custom_rdout #(
   parameter int WIDTH  = 409,
   parameter int NWORDS = 13,
   parameter int IDXW   = $clog2(NWORDS)
) (
   input logic                   clk,
   input logic                   rst_l,
   input logic                   scan_mode,
   el2_exu_custom_rdout_if.slave bus
);

   localparam int PADW = NWORDS * 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READY = 2'd1,
      ST_PEND  = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      OP_START = 2'd0,
      OP_INC   = 2'd1,
      OP_END   = 2'd2
   } op_e;

   // Bits at or above WIDTH read back as zero in the top word.
   function automatic logic [31:0] word_sel(input logic [WIDTH-1:0] src, input logic [IDXW-1:0] k);
      logic [PADW-1:0] pad;
      pad = '0;
      pad[WIDTH-1:0] = src;
      return pad[int'(k) * 32 +: 32];
   endfunction

   function automatic logic [IDXW-1:0] next_idx(input op_e op, input logic [IDXW-1:0] cur);
      logic [IDXW-1:0] nxt;
      case (op)
         OP_START: nxt = IDXW'(1);
         OP_INC:   nxt = (cur == IDXW'(NWORDS - 1)) ? '0 : cur + IDXW'(1);
         OP_END:   nxt = '0;
         default:  nxt = '0;
      endcase
      return nxt;
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [31:0]      rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             busy_q, busy_d;
   logic             res_vld_q, res_vld_d;
   logic             err_q, err_d;
`ifdef EL2_FFRD_STALL_EN
   op_e              op_q, op_d;
`endif

   logic             rd_req_s;
   op_e              req_op_s;
   logic             serve_s;
   op_e              serve_op_s;
   logic [WIDTH-1:0] serve_src_s;
   logic [IDXW-1:0]  serve_k_s;
   logic             zero_s;
   logic             drop_s;
   logic             hold_new_s;
   logic             unused_scan_s;

   assign unused_scan_s = scan_mode;

   // Request decode: start beats end, end beats inc.
   always_comb begin
      rd_req_s = bus.rd_start_i | bus.rd_inc_i | bus.rd_end_i;
      if (bus.rd_start_i) begin
         req_op_s = OP_START;
      end else if (bus.rd_end_i) begin
         req_op_s = OP_END;
      end else begin
         req_op_s = OP_INC;
      end
   end

   // Next-state, capture and word-return logic.
   always_comb begin
      state_d     = state_q;
      res_d       = res_q;
      idx_d       = idx_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      err_d       = err_q;
      serve_s     = 1'b0;
      serve_op_s  = req_op_s;
      serve_src_s = res_q;
      serve_k_s   = '0;
      zero_s      = 1'b0;
      drop_s      = 1'b0;
      hold_new_s  = 1'b0;
`ifdef EL2_FFRD_STALL_EN
      op_d        = op_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (bus.finish_p_i) begin
               res_d       = bus.result_i;
               state_d     = ST_READY;
               hold_new_s  = 1'b1;
               serve_s     = rd_req_s;
               serve_src_s = bus.result_i;
            end else if (rd_req_s) begin
`ifdef EL2_FFRD_STALL_EN
               state_d = ST_PEND;
               op_d    = req_op_s;
`else
               serve_s = 1'b1;
               zero_s  = 1'b1;
               err_d   = 1'b1;
`endif
            end else if (bus.clear_i) begin
               idx_d = '0;
            end else begin
               idx_d = idx_q;
            end
         end
         ST_READY: begin
            serve_s = rd_req_s;
            if (bus.finish_p_i) begin
               res_d      = bus.result_i;
               hold_new_s = 1'b1;
            end else if (bus.clear_i) begin
               drop_s  = 1'b1;
               idx_d   = '0;
               state_d = ST_IDLE;
            end else begin
               res_d = res_q;
            end
         end
`ifdef EL2_FFRD_STALL_EN
         ST_PEND: begin
            if (rd_req_s) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
            // The latched request is answered straight from the incoming result.
            if (bus.finish_p_i) begin
               res_d       = bus.result_i;
               serve_s     = 1'b1;
               serve_op_s  = op_q;
               serve_src_s = bus.result_i;
            end else if (bus.clear_i) begin
               idx_d = '0;
            end else begin
               idx_d = idx_q;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (serve_s) begin
         rd_valid_d = 1'b1;
         if (serve_op_s == OP_START) begin
            serve_k_s = '0;
         end else begin
            serve_k_s = idx_q;
         end
         rd_data_d = zero_s ? 32'h0000_0000 : word_sel(serve_src_s, serve_k_s);
         if (drop_s) begin
            idx_d = '0;
         end else begin
            idx_d = next_idx(serve_op_s, idx_q);
         end
         // A fresh capture in the same cycle keeps a result held even after an end.
         if (zero_s || drop_s) begin
            state_d = ST_IDLE;
         end else if ((serve_op_s == OP_END) && !hold_new_s) begin
            state_d = ST_IDLE;
         end else begin
            state_d = ST_READY;
         end
      end else begin
         rd_valid_d = 1'b0;
      end

`ifdef EL2_FFRD_STALL_EN
      busy_d = (state_d == ST_PEND);
`else
      busy_d = 1'b0;
`endif
      res_vld_d = (state_d == ST_READY);
   end

   // State, held result and registered outputs.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q    <= ST_IDLE;
         res_q      <= '0;
         idx_q      <= '0;
         rd_data_q  <= 32'h0000_0000;
         rd_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         res_vld_q  <= 1'b0;
         err_q      <= 1'b0;
`ifdef EL2_FFRD_STALL_EN
         op_q       <= OP_START;
`endif
      end else begin
         state_q    <= state_d;
         res_q      <= res_d;
         idx_q      <= idx_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         busy_q     <= busy_d;
         res_vld_q  <= res_vld_d;
         err_q      <= err_d;
`ifdef EL2_FFRD_STALL_EN
         op_q       <= op_d;
`endif
      end
   end

   assign bus.rd_data_o  = rd_data_q;
   assign bus.rd_valid_o = rd_valid_q;
   assign bus.busy_o     = busy_q;
   assign bus.res_vld_o  = res_vld_q;
   assign bus.idx_o      = idx_q;
   assign bus.err_o      = err_q;

endmodule
